// File: rtl/write_back.sv
// -----------------------------------------------------------------------------
// write_back
//
// Write-back stage of a five-stage Y86-64 style pipeline. Holds the W pipeline
// register, the 15-entry general-purpose register file, the sticky processor
// status FSM and the retired-instruction counter.
//
// Ports
//   clk_i          single clock, all state updates on its rising edge
//   rst_i          synchronous, active-high reset
//   W_stall_i      hold the W register contents (wins over W_bubble_i)
//   W_bubble_i     load a bubble (nop) into the W register
//   M_icode_i      icode of the instruction leaving the memory stage
//   M_valE_i       ALU result from the memory stage
//   m_valM_i       memory read data
//   M_dstE_i       destination register for valE
//   M_dstM_i       destination register for valM
//   m_stat_i       status produced by the memory access
//   srcA_i/srcB_i  decode-stage register read addresses
//   W_*_o          registered W-stage fields, used by decode forwarding
//   rvalA_o/B_o    register file read data (combinational)
//   stat_o         sticky processor status (SAOK while running)
//   halted_o       processor stopped
//   retired_o      count of retired instructions (wraps silently)
//
// Handshake: there is no valid/ready pair at this boundary. Each rising edge
// the W register either holds (stall or halted), takes a bubble, or loads the
// M-side fields; an internal valid flag marks an entry that has not yet
// retired, so a held entry retires (counts and writes) exactly once.
// -----------------------------------------------------------------------------
module write_back #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [2:0] SAOK  = 3'd1,
    parameter logic [2:0] SHLT  = 3'd2,
    parameter logic [2:0] SADR  = 3'd3,
    parameter logic [2:0] SINS  = 3'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        W_stall_i,
    input  logic        W_bubble_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] m_valM_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [2:0]  m_stat_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [3:0]  W_icode_o,
    output logic [63:0] W_valE_o,
    output logic [63:0] W_valM_o,
    output logic [3:0]  W_dstE_o,
    output logic [3:0]  W_dstM_o,
    output logic [2:0]  W_stat_o,
    output logic [63:0] rvalA_o,
    output logic [63:0] rvalB_o,
    output logic [2:0]  stat_o,
    output logic        halted_o,
    output logic [63:0] retired_o
);

    // icode loaded by a bubble
    localparam logic [3:0] INOP = 4'h1;
    // Architectural ID with no backing storage, independent of RNONE
    localparam logic [3:0] ID_NONE_HW = 4'hF;
    localparam int         NUM_REGS   = 15;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [3:0]  r_icode;
    logic [63:0] r_valE;
    logic [63:0] r_valM;
    logic [3:0]  r_dstE;
    logic [3:0]  r_dstM;
    logic [2:0]  r_stat;
    logic        r_valid;

    logic [63:0] r_regs [0:NUM_REGS-1];

    state_t      r_state;
    logic [2:0]  r_halt_stat;
    logic [63:0] r_retired;

    // -------------------------------------------------------------------------
    // Derived control
    // -------------------------------------------------------------------------
    state_t      w_state_next;
    logic        w_halted;
    logic        w_enter_halt;
    logic        w_retire;
    logic        w_we_e;
    logic        w_we_m;

    assign w_halted = (r_state == ST_HALT);

    // An entry retires once: it must be unretired, error-free, and the
    // processor must still be running.
    assign w_retire = r_valid && (r_stat == SAOK) && !w_halted;

    // Register writes ride on retirement, so a stalled entry writes once and
    // a faulting entry never writes.
    assign w_we_e = w_retire && (r_dstE != RNONE) && (r_dstE != ID_NONE_HW);
    assign w_we_m = w_retire && (r_dstM != RNONE) && (r_dstM != ID_NONE_HW);

    assign w_enter_halt = (r_state == ST_RUN) && (w_state_next == ST_HALT);

    // -------------------------------------------------------------------------
    // W pipeline register
    // Priority: reset > halted (freeze) > stall (hold) > bubble > load
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_icode <= INOP;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_stat  <= SAOK;
            r_valid <= 1'b0;
        end else if (w_halted) begin
            // Frozen: the faulting context stays visible for debug.
            r_valid <= r_valid;
        end else if (W_stall_i) begin
            // Contents held; once the held entry has retired it must not
            // retire again on the following held cycles.
            r_valid <= r_valid && !w_retire;
        end else if (W_bubble_i) begin
            r_icode <= INOP;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_stat  <= SAOK;
            r_valid <= 1'b0;
        end else begin
            r_icode <= M_icode_i;
            r_valE  <= M_valE_i;
            r_valM  <= m_valM_i;
            r_dstE  <= M_dstE_i;
            r_dstM  <= M_dstM_i;
            r_stat  <= m_stat_i;
            r_valid <= 1'b1;
        end
    end

    assign W_icode_o = r_icode;
    assign W_valE_o  = r_valE;
    assign W_valM_o  = r_valM;
    assign W_dstE_o  = r_dstE;
    assign W_dstM_o  = r_dstM;
    assign W_stat_o  = r_stat;

    // -------------------------------------------------------------------------
    // Register file
    // The valM write is issued last so it wins when dstE == dstM (a popq of
    // %rsp must leave the popped value, not the incremented stack pointer).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_we_e) begin
                r_regs[r_dstE] <= r_valE;
            end
            if (w_we_m) begin
                r_regs[r_dstM] <= r_valM;
            end
        end
    end

    // Reads see array contents only; a write on this edge becomes visible
    // after it, and decode forwarding from W_*_o covers the gap.
    always_comb begin
        rvalA_o = '0;
        rvalB_o = '0;
        if (srcA_i != ID_NONE_HW) begin
            rvalA_o = r_regs[srcA_i];
        end
        if (srcB_i != ID_NONE_HW) begin
            rvalB_o = r_regs[srcB_i];
        end
    end

    // -------------------------------------------------------------------------
    // Status FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_halt_stat <= SAOK;
        end else begin
            r_state <= w_state_next;
            if (w_enter_halt) begin
                r_halt_stat <= r_stat;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status FSM: next-state logic
    // Only a real (valid) entry can stop the machine; bubbles carry SAOK.
    // Unknown status codes are treated as faults as well.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (r_valid) begin
                    case (r_stat)
                        SAOK:             w_state_next = ST_RUN;
                        SHLT, SADR, SINS: w_state_next = ST_HALT;
                        default:          w_state_next = ST_HALT;
                    endcase
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Status FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        halted_o = w_halted;
        stat_o   = SAOK;
        if (w_halted) begin
            stat_o = r_halt_stat;
        end
    end

    // -------------------------------------------------------------------------
    // Retired-instruction counter (wraps modulo 2^64)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 64'd1;
        end
    end

    assign retired_o = r_retired;

endmodule
